// File: rtl/ram_port_arbiter.sv
// -----------------------------------------------------------------------------
// ram_port_arbiter
//   Shares one single-port write-first block RAM between two requesters.
//   Port A is the high-priority side (scan-out reads); port B is the
//   low-priority side (renderer/CPU read-write). Fixed priority with a
//   starvation counter that forces a B grant after MAX_WAIT lost conflicts.
//   The RAM's registered read data is routed back to whichever port issued
//   the read, exactly one cycle after the transfer.
//
// Optional feature macro: ARB_LOCK_EN
//   When defined, adds a_lock_i/b_lock_i and a lock FSM (UNLOCKED, LOCK_A,
//   LOCK_B) that lets a granted port hold the RAM for a burst.
//
// Ports
//   clk_i            rising-edge clock
//   reset_i          synchronous, active-high reset
//   x_valid_i        request present            (x = a | b)
//   x_ready_o        request accepted this cycle (combinational grant)
//   x_we_i           write (1) / read (0)
//   x_addr_i         request address
//   x_wdata_i        request write data
//   x_rsp_valid_o    read data valid, one cycle after a read transfer
//   x_rsp_data_o     read data, 0 when not the response owner
//   x_lock_i         burst lock (ARB_LOCK_EN only)
//   ram_en_o         RAM enable
//   ram_we_o         RAM write enable
//   ram_addr_o       RAM address
//   ram_di_o         RAM write data
//   ram_dout_i       RAM read data, registered inside the RAM
// -----------------------------------------------------------------------------
module ram_port_arbiter #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MAX_WAIT   = 4,
  parameter int unsigned CNT_WIDTH  = 3
) (
  input  logic                  clk_i,
  input  logic                  reset_i,

  input  logic                  a_valid_i,
  output logic                  a_ready_o,
  input  logic                  a_we_i,
  input  logic [ADDR_WIDTH-1:0] a_addr_i,
  input  logic [DATA_WIDTH-1:0] a_wdata_i,
  output logic                  a_rsp_valid_o,
  output logic [DATA_WIDTH-1:0] a_rsp_data_o,

  input  logic                  b_valid_i,
  output logic                  b_ready_o,
  input  logic                  b_we_i,
  input  logic [ADDR_WIDTH-1:0] b_addr_i,
  input  logic [DATA_WIDTH-1:0] b_wdata_i,
  output logic                  b_rsp_valid_o,
  output logic [DATA_WIDTH-1:0] b_rsp_data_o,

`ifdef ARB_LOCK_EN
  input  logic                  a_lock_i,
  input  logic                  b_lock_i,
`endif

  output logic                  ram_en_o,
  output logic                  ram_we_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [DATA_WIDTH-1:0] ram_di_o,
  input  logic [DATA_WIDTH-1:0] ram_dout_i
);

  // Response owner encoding
  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_A    = 2'd1;
  localparam logic [1:0] OWN_B    = 2'd2;

  localparam logic [CNT_WIDTH-1:0] WAIT_MAX = CNT_WIDTH'(MAX_WAIT);

  logic [CNT_WIDTH-1:0] wait_cnt_q, wait_cnt_d;
  logic [1:0]           rsp_owner_q, rsp_owner_d;
  logic                 grant_a, grant_b;
  logic                 starved;
  logic                 hold_a, hold_b;

  assign starved = (wait_cnt_q == WAIT_MAX);

`ifdef ARB_LOCK_EN
  // Lock FSM states
  localparam logic [1:0] ST_UNLOCKED = 2'd0;
  localparam logic [1:0] ST_LOCK_A   = 2'd1;
  localparam logic [1:0] ST_LOCK_B   = 2'd2;

  logic [1:0] state_q, state_d;

  // A lock is only in force while its owner keeps x_lock high; the cycle the
  // lock drops is arbitrated as if unlocked.
  assign hold_a = (state_q == ST_LOCK_A) && a_lock_i;
  assign hold_b = (state_q == ST_LOCK_B) && b_lock_i;

  // Lock state register
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_UNLOCKED;
    end else begin
      state_q <= state_d;
    end
  end

  // Lock next-state: a lock in force persists; otherwise a locked grant
  // enters the matching lock state and anything else returns to UNLOCKED.
  always_comb begin
    state_d = state_q;
    if (hold_a || hold_b) begin
      state_d = state_q;
    end else if (grant_a && a_lock_i) begin
      state_d = ST_LOCK_A;
    end else if (grant_b && b_lock_i) begin
      state_d = ST_LOCK_B;
    end else begin
      state_d = ST_UNLOCKED;
    end
  end
`else
  assign hold_a = 1'b0;
  assign hold_b = 1'b0;
`endif

  // Grant: lock holder first, then fixed priority with starvation override.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!reset_i) begin
      if (hold_a) begin
        grant_a = a_valid_i;
      end else if (hold_b) begin
        grant_b = b_valid_i;
      end else if (a_valid_i && b_valid_i) begin
        if (starved) begin
          grant_b = 1'b1;
        end else begin
          grant_a = 1'b1;
        end
      end else begin
        grant_a = a_valid_i;
        grant_b = b_valid_i;
      end
    end
  end

  // Starvation counter: counts B's lost cycles, saturating at MAX_WAIT.
  always_comb begin
    wait_cnt_d = '0;
    if (b_valid_i && !grant_b) begin
      if (wait_cnt_q >= WAIT_MAX) begin
        wait_cnt_d = WAIT_MAX;
      end else begin
        wait_cnt_d = wait_cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  // Response owner for the read issued this cycle.
  always_comb begin
    rsp_owner_d = OWN_NONE;
    if (grant_a && !a_we_i) begin
      rsp_owner_d = OWN_A;
    end else if (grant_b && !b_we_i) begin
      rsp_owner_d = OWN_B;
    end
  end

  // Arbiter state registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wait_cnt_q  <= '0;
      rsp_owner_q <= OWN_NONE;
    end else begin
      wait_cnt_q  <= wait_cnt_d;
      rsp_owner_q <= rsp_owner_d;
    end
  end

  // RAM request mux; idle cycles drive zeros.
  always_comb begin
    ram_en_o   = 1'b0;
    ram_we_o   = 1'b0;
    ram_addr_o = '0;
    ram_di_o   = '0;
    if (grant_a) begin
      ram_en_o   = 1'b1;
      ram_we_o   = a_we_i;
      ram_addr_o = a_addr_i;
      ram_di_o   = a_wdata_i;
    end else if (grant_b) begin
      ram_en_o   = 1'b1;
      ram_we_o   = b_we_i;
      ram_addr_o = b_addr_i;
      ram_di_o   = b_wdata_i;
    end
  end

  assign a_ready_o = grant_a;
  assign b_ready_o = grant_b;

  // Read data return; suppressed while reset is high.
  assign a_rsp_valid_o = !reset_i && (rsp_owner_q == OWN_A);
  assign b_rsp_valid_o = !reset_i && (rsp_owner_q == OWN_B);
  assign a_rsp_data_o  = a_rsp_valid_o ? ram_dout_i : '0;
  assign b_rsp_data_o  = b_rsp_valid_o ? ram_dout_i : '0;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_ram_port_arbiter
//   Self-checking bench: a behavioural RAM sits on the RAM port, a reference
//   model of the arbitration rules is compared against the DUT every cycle,
//   and directed sequences pin literal expectations.
// -----------------------------------------------------------------------------
module tb_ram_port_arbiter;

  localparam int MAX_WAIT = 4;

`ifdef ARB_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       a_valid, a_ready, a_we, a_rsp_valid;
  logic [7:0] a_addr, a_wdata, a_rsp_data;
  logic       b_valid, b_ready, b_we, b_rsp_valid;
  logic [7:0] b_addr, b_wdata, b_rsp_data;
  logic       a_lock, b_lock;
  logic       ram_en, ram_we;
  logic [7:0] ram_addr, ram_di, ram_dout;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ram_port_arbiter #(
    .ADDR_WIDTH(8), .DATA_WIDTH(8), .MAX_WAIT(MAX_WAIT), .CNT_WIDTH(3)
  ) dut (
    .clk_i(clk), .reset_i(reset),
    .a_valid_i(a_valid), .a_ready_o(a_ready), .a_we_i(a_we),
    .a_addr_i(a_addr), .a_wdata_i(a_wdata),
    .a_rsp_valid_o(a_rsp_valid), .a_rsp_data_o(a_rsp_data),
    .b_valid_i(b_valid), .b_ready_o(b_ready), .b_we_i(b_we),
    .b_addr_i(b_addr), .b_wdata_i(b_wdata),
    .b_rsp_valid_o(b_rsp_valid), .b_rsp_data_o(b_rsp_data),
`ifdef ARB_LOCK_EN
    .a_lock_i(a_lock), .b_lock_i(b_lock),
`endif
    .ram_en_o(ram_en), .ram_we_o(ram_we), .ram_addr_o(ram_addr),
    .ram_di_o(ram_di), .ram_dout_i(ram_dout)
  );

  function automatic logic [7:0] init_val(input int i);
    logic [7:0] v;
    v = 8'(i) ^ 8'hC3;
    if (i == 16) v = 8'h5A;
    return v;
  endfunction

  // Write-first single-port RAM with registered output
  logic [7:0] ram_mem [256];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) begin
        ram_mem[ram_addr] <= ram_di;
        ram_dout          <= ram_di;
      end else begin
        ram_dout <= ram_mem[ram_addr];
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int         m_cnt   = 0;   // B's lost conflict cycles
  int         m_lock  = 0;   // 0 none, 1 A holds, 2 B holds
  int         m_owner = 0;   // 0 none, 1 A, 2 B: who gets data this cycle
  logic [7:0] m_rdata = '0;
  logic [7:0] m_mem [256];

  always @(negedge clk) begin
    bit         ga, gb, la, lb, rst;
    logic [7:0] e_addr, e_di;
    bit         e_we;
    rst = (reset === 1'b1);

    check("a_rsp_valid", a_rsp_valid, !rst && m_owner == 1);
    check("b_rsp_valid", b_rsp_valid, !rst && m_owner == 2);
    check("a_rsp_data", a_rsp_data, (!rst && m_owner == 1) ? m_rdata : 8'h00);
    check("b_rsp_data", b_rsp_data, (!rst && m_owner == 2) ? m_rdata : 8'h00);

    la = LOCK_EN && m_lock == 1 && a_lock;
    lb = LOCK_EN && m_lock == 2 && b_lock;
    ga = 0; gb = 0;
    if (!rst) begin
      if (la)                      ga = a_valid;
      else if (lb)                 gb = b_valid;
      else if (a_valid && b_valid) begin
        if (m_cnt == MAX_WAIT) gb = 1; else ga = 1;
      end else begin
        ga = a_valid; gb = b_valid;
      end
    end

    e_we = ga ? a_we : (gb ? b_we : 1'b0);
    e_addr = ga ? a_addr : (gb ? b_addr : 8'h00);
    e_di = ga ? a_wdata : (gb ? b_wdata : 8'h00);
    check("a_ready", a_ready, ga);
    check("b_ready", b_ready, gb);
    check("ram_en", ram_en, ga || gb);
    check("ram_we", ram_we, e_we);
    check("ram_addr", ram_addr, e_addr);
    check("ram_di", ram_di, e_di);

    if (rst) begin
      m_cnt = 0; m_lock = 0; m_owner = 0;
    end else begin
      m_owner = 0;
      if (ga || gb) begin
        if (e_we) m_mem[e_addr] = e_di;
        else begin
          m_owner = ga ? 1 : 2;
          m_rdata = m_mem[e_addr];
        end
      end
      if (b_valid && !gb) m_cnt = (m_cnt + 1 > MAX_WAIT) ? MAX_WAIT : m_cnt + 1;
      else m_cnt = 0;
      if (!(la || lb)) begin
        if (LOCK_EN && ga && a_lock)      m_lock = 1;
        else if (LOCK_EN && gb && b_lock) m_lock = 2;
        else                              m_lock = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a_valid = 0; a_we = 0; a_addr = 0; a_wdata = 0; a_lock = 0;
    b_valid = 0; b_we = 0; b_addr = 0; b_wdata = 0; b_lock = 0;
  endtask

  task automatic req_a(input logic we, input logic [7:0] addr, input logic [7:0] wd);
    a_valid = 1; a_we = we; a_addr = addr; a_wdata = wd;
  endtask

  task automatic req_b(input logic we, input logic [7:0] addr, input logic [7:0] wd);
    b_valid = 1; b_we = we; b_addr = addr; b_wdata = wd;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram_mem[i] = init_val(i);
      m_mem[i]   = init_val(i);
    end
    ram_dout = '0;
    idle();
    reset = 1;
    req_a(0, 8'h10, 0);
    req_b(0, 8'h20, 0);
    #3;
    check("rst_a_ready", a_ready, 0);
    check("rst_ram_en", ram_en, 0);
    check("rst_a_rsp_valid", a_rsp_valid, 0);
    tick(); tick();
    reset = 0;
    idle();
    tick();

    // Single read of 0x10
    req_a(0, 8'h10, 0);
    #3;
    check("rd_ram_en", ram_en, 1);
    check("rd_a_ready", a_ready, 1);
    tick();
    idle();
    #3;
    check("rd_a_rsp_valid", a_rsp_valid, 1);
    check("rd_a_rsp_data", a_rsp_data, 8'h5A);
    check("rd_b_rsp_valid", b_rsp_valid, 0);
    tick();

    // B write 0x33 to 0x04 then read it back
    req_b(1, 8'h04, 8'h33);
    #3;
    check("wr_b_ready", b_ready, 1);
    tick();
    req_b(0, 8'h04, 0);
    #3;
    check("wr_rd_b_ready", b_ready, 1);
    check("wr_no_rsp", b_rsp_valid, 0);
    tick();
    idle();
    #3;
    check("wr_rd_b_rsp_valid", b_rsp_valid, 1);
    check("wr_rd_b_rsp_data", b_rsp_data, 8'h33);
    tick();

    // Priority conflict for one cycle
    req_a(0, 8'h01, 0);
    req_b(0, 8'h02, 0);
    #3;
    check("pri_a_ready", a_ready, 1);
    check("pri_b_ready", b_ready, 0);
    tick();
    a_valid = 0;
    #3;
    check("pri_b_next", b_ready, 1);
    check("pri_a_rsp", a_rsp_data, 8'hC2);
    tick();
    idle();
    #3;
    check("pri_b_rsp", b_rsp_data, 8'hC1);
    tick();

    // Continuous conflict: four A grants then one B grant, repeating
    for (int k = 0; k < 10; k++) begin
      req_a(0, 8'(k), 0);
      req_b(0, 8'(k + 32), 0);
      #3;
      check("starve_b_ready", b_ready, (k % 5) == 4);
      check("starve_a_ready", a_ready, (k % 5) != 4);
      tick();
    end
    idle();
    tick();

    // Reset while B is partly starved and A is reading
    for (int k = 0; k < 3; k++) begin
      req_a(0, 8'(k), 0);
      req_b(0, 8'h40, 0);
      tick();
    end
    reset = 1;
    #3;
    check("rstmid_a_ready", a_ready, 0);
    tick();
    reset = 0;
    for (int k = 0; k < 5; k++) begin
      req_a(0, 8'(k + 8), 0);
      req_b(0, 8'h41, 0);
      #3;
      if (k == 0) check("rstmid_no_rsp", a_rsp_valid, 0);
      check("rstmid_b_ready", b_ready, k == 4);
      tick();
    end
    idle();
    tick();

`ifdef ARB_LOCK_EN
    // B locks the RAM for three cycles while A waits
    b_lock = 1;
    req_b(0, 8'h50, 0);
    #3;
    check("lock_b_first", b_ready, 1);
    tick();
    for (int k = 0; k < 2; k++) begin
      req_a(0, 8'h60, 0);
      #3;
      check("lock_a_blocked", a_ready, 0);
      check("lock_b_held", b_ready, 1);
      tick();
    end
    b_valid = 0;
    #3;
    check("lock_idle_a_blocked", a_ready, 0);
    tick();
    b_lock = 0;
    req_b(0, 8'h51, 0);
    #3;
    check("lock_release_a", a_ready, 1);
    tick();
    idle();
    tick();
`endif

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      a_valid = ($urandom_range(0, 9) < 7);
      a_we    = ($urandom_range(0, 9) < 3);
      a_addr  = 8'($urandom_range(0, 15));
      a_wdata = 8'($urandom);
      a_lock  = ($urandom_range(0, 3) != 0) ? a_lock : ~a_lock;
      b_valid = ($urandom_range(0, 9) < 7);
      b_we    = ($urandom_range(0, 9) < 4);
      b_addr  = 8'($urandom_range(0, 15));
      b_wdata = 8'($urandom);
      b_lock  = ($urandom_range(0, 3) != 0) ? b_lock : ~b_lock;
      reset   = ($urandom_range(0, 63) == 0);
      tick();
    end
    reset = 0;
    idle();
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
